// File: rtl/control_sequencer.sv
// Five-step microcode sequencer; conditional jumps JC/JZ enabled by SEQ_COND_JUMP_EN.
// Latency: controls decode combinationally from the current step; step/halted update on posedge clk.
// Backpressure: run=0 or halted freezes step and zeroes every control output.
module control_sequencer #(
   parameter int IR_WIDTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic [IR_WIDTH-1:0] ir_in,
   input  logic                flag_c,
   input  logic                flag_z,
   output logic [2:0]          step,
   output logic                pc_enable,
   output logic                pc_load,
   output logic                pc_out,
   output logic                mar_load,
   output logic                ram_read,
   output logic                ram_write,
   output logic                ir_load,
   output logic                ir_out,
   output logic                a_load,
   output logic                a_out,
   output logic                b_load,
   output logic                alu_out,
   output logic                alu_sub,
   output logic                flags_load,
   output logic                out_load,
   output logic                halted
);

   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   logic [3:0] opcode;
   logic [2:0] step_nxt;
   logic       halted_nxt;
   logic       active;
   logic       unused_ir;

   assign opcode    = ir_in[IR_WIDTH-1 -: 4];
   assign unused_ir = ^ir_in[IR_WIDTH-5:0];
   // reset gates the decode too, so controls drop the instant reset rises
   assign active    = !reset && run && !halted;

`ifdef SEQ_COND_JUMP_EN
   logic jc_take;
   logic jz_take;
   assign jc_take = (opcode == OP_JC) && flag_c;
   assign jz_take = (opcode == OP_JZ) && flag_z;
`else
   logic unused_flags;
   assign unused_flags = flag_c ^ flag_z ^ (opcode == OP_JC) ^ (opcode == OP_JZ);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step   <= 3'd0;
         halted <= 1'b0;
      end else begin
         step   <= step_nxt;
         halted <= halted_nxt;
      end
   end

   always_comb begin
      step_nxt   = step;
      halted_nxt = halted;
      if (run && !halted) begin
         if (step > 3'd4) begin
            step_nxt = 3'd0;
         end else if (step == 3'd2 && opcode == OP_HLT) begin
            halted_nxt = 1'b1;
         end else if (step == 3'd4) begin
            step_nxt = 3'd0;
         end else begin
            step_nxt = step + 3'd1;
         end
      end
   end

   always_comb begin
      pc_enable  = 1'b0;
      pc_load    = 1'b0;
      pc_out     = 1'b0;
      mar_load   = 1'b0;
      ram_read   = 1'b0;
      ram_write  = 1'b0;
      ir_load    = 1'b0;
      ir_out     = 1'b0;
      a_load     = 1'b0;
      a_out      = 1'b0;
      b_load     = 1'b0;
      alu_out    = 1'b0;
      alu_sub    = 1'b0;
      flags_load = 1'b0;
      out_load   = 1'b0;
      if (active) begin
         case (step)
            3'd0: begin
               pc_out   = 1'b1;
               mar_load = 1'b1;
            end
            3'd1: begin
               ram_read  = 1'b1;
               ir_load   = 1'b1;
               pc_enable = 1'b1;
            end
            3'd2: begin
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     ir_out   = 1'b1;
                     mar_load = 1'b1;
                  end
                  OP_LDI: begin
                     ir_out = 1'b1;
                     a_load = 1'b1;
                  end
                  OP_JMP: begin
                     ir_out  = 1'b1;
                     pc_load = 1'b1;
                  end
                  OP_OUT: begin
                     a_out    = 1'b1;
                     out_load = 1'b1;
                  end
                  default: begin
`ifdef SEQ_COND_JUMP_EN
                     if (jc_take || jz_take) begin
                        ir_out  = 1'b1;
                        pc_load = 1'b1;
                     end
`endif
                  end
               endcase
            end
            3'd3: begin
               case (opcode)
                  OP_LDA: begin
                     ram_read = 1'b1;
                     a_load   = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     ram_read = 1'b1;
                     b_load   = 1'b1;
                  end
                  OP_STA: begin
                     a_out     = 1'b1;
                     ram_write = 1'b1;
                  end
                  default: ;
               endcase
            end
            3'd4: begin
               if (opcode == OP_ADD || opcode == OP_SUB) begin
                  alu_out    = 1'b1;
                  a_load     = 1'b1;
                  flags_load = 1'b1;
                  alu_sub    = (opcode == OP_SUB);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: microcode table model plus directed and randomized scenarios.
module tb_control_sequencer;

   localparam logic [14:0] PCE  = 15'h4000;
   localparam logic [14:0] PCL  = 15'h2000;
   localparam logic [14:0] PCO  = 15'h1000;
   localparam logic [14:0] MARL = 15'h0800;
   localparam logic [14:0] RAMR = 15'h0400;
   localparam logic [14:0] RAMW = 15'h0200;
   localparam logic [14:0] IRL  = 15'h0100;
   localparam logic [14:0] IRO  = 15'h0080;
   localparam logic [14:0] AL   = 15'h0040;
   localparam logic [14:0] AO   = 15'h0020;
   localparam logic [14:0] BL   = 15'h0010;
   localparam logic [14:0] ALUO = 15'h0008;
   localparam logic [14:0] SUBB = 15'h0004;
   localparam logic [14:0] FL   = 15'h0002;
   localparam logic [14:0] OL   = 15'h0001;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       run = 1'b0;
   logic [7:0] ir_in = 8'h00;
   logic       flag_c = 1'b0;
   logic       flag_z = 1'b0;
   logic [2:0] step;
   logic       pc_enable, pc_load, pc_out, mar_load, ram_read, ram_write, ir_load, ir_out;
   logic       a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load, halted;
   logic [14:0] dut_ctl;

   int checks = 0;
   int errors = 0;
   int m_step = 0;
   bit m_halted = 1'b0;
   logic [14:0] ucode [16][5];
   bit cond_en;

   always #5 clk = ~clk;

   control_sequencer #(.IR_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .run(run), .ir_in(ir_in), .flag_c(flag_c), .flag_z(flag_z),
      .step(step), .pc_enable(pc_enable), .pc_load(pc_load), .pc_out(pc_out),
      .mar_load(mar_load), .ram_read(ram_read), .ram_write(ram_write), .ir_load(ir_load),
      .ir_out(ir_out), .a_load(a_load), .a_out(a_out), .b_load(b_load), .alu_out(alu_out),
      .alu_sub(alu_sub), .flags_load(flags_load), .out_load(out_load), .halted(halted)
   );

   assign dut_ctl = {pc_enable, pc_load, pc_out, mar_load, ram_read, ram_write, ir_load,
                     ir_out, a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load};

   task automatic init_ucode();
      for (int op = 0; op < 16; op++) begin
         ucode[op][0] = PCO | MARL;
         ucode[op][1] = RAMR | IRL | PCE;
         for (int s = 2; s < 5; s++) ucode[op][s] = '0;
      end
      ucode[1][2] = IRO | MARL;  ucode[1][3] = RAMR | AL;
      ucode[2][2] = IRO | MARL;  ucode[2][3] = RAMR | BL;  ucode[2][4] = ALUO | AL | FL;
      ucode[3][2] = IRO | MARL;  ucode[3][3] = RAMR | BL;  ucode[3][4] = ALUO | AL | FL | SUBB;
      ucode[4][2] = IRO | MARL;  ucode[4][3] = AO | RAMW;
      ucode[5][2] = IRO | AL;
      ucode[6][2] = IRO | PCL;
      ucode[14][2] = AO | OL;
   endtask

   // Expected controls for the present inputs and model state.
   function automatic logic [14:0] exp_ctl();
      int op;
      logic [14:0] v;
      op = int'(ir_in[7:4]);
      if (reset || !run || m_halted || m_step > 4) return '0;
      v = ucode[op][m_step];
      if (cond_en && m_step == 2 && ((op == 7 && flag_c) || (op == 8 && flag_z)))
         v = IRO | PCL;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      if (!reset && run && !m_halted) begin
         if (m_step == 2 && ir_in[7:4] == 4'hF) m_halted = 1'b1;
         else m_step = (m_step + 1) % 5;
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_step = 0;
      m_halted = 1'b0;
   endtask

   task automatic test_reset();
      run = 1'b1;
      ir_in = 8'h20;
      reset = 1'b1;
      #1;
      checks++;
      if ({halted, step, dut_ctl} !== {1'b0, 3'd0, 15'h0}) begin
         errors++;
         $display("FAIL reset_state: got halted=%0b step=%0d ctl=%h, need 0/0/0000", halted, step, dut_ctl);
      end
      do_reset();
   endtask

   task automatic test_fetch_nop();
      do_reset();
      run = 1'b1;
      ir_in = 8'h00;
      #1;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (step !== 3'(i % 5) || dut_ctl !== exp_ctl()) begin
            errors++;
            $display("FAIL nop_seq[%0d]: got step=%0d ctl=%h, need step=%0d ctl=%h", i, step, dut_ctl, i % 5, exp_ctl());
         end
         tick();
      end
   endtask

   task automatic test_sub();
      do_reset();
      run = 1'b1;
      ir_in = 8'h3A;
      #1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (dut_ctl !== exp_ctl() || alu_sub !== (i == 4)) begin
            errors++;
            $display("FAIL sub_step%0d: got ctl=%h alu_sub=%0b, need ctl=%h alu_sub=%0b", i, dut_ctl, alu_sub, exp_ctl(), i == 4);
         end
         tick();
      end
   endtask

   task automatic test_halt();
      do_reset();
      run = 1'b1;
      ir_in = 8'hF0;
      tick();
      tick();
      checks++;
      if ({halted, step, dut_ctl} !== {1'b0, 3'd2, 15'h0}) begin
         errors++;
         $display("FAIL hlt_t2: got halted=%0b step=%0d ctl=%h, need 0/2/0000", halted, step, dut_ctl);
      end
      for (int i = 0; i < 11; i++) begin
         if (i == 5) run = 1'b0;
         if (i == 7) run = 1'b1;
         tick();
         checks++;
         if ({halted, step, dut_ctl} !== {m_halted, 3'(m_step), 15'h0} || !m_halted || m_step != 2) begin
            errors++;
            $display("FAIL halted_hold[%0d]: got halted=%0b step=%0d ctl=%h, need 1/2/0000", i, halted, step, dut_ctl);
         end
      end
      #2;
      reset = 1'b1;
      #1;
      m_step = 0;
      m_halted = 1'b0;
      checks++;
      if ({halted, step, dut_ctl} !== {1'b0, 3'd0, 15'h0}) begin
         errors++;
         $display("FAIL hlt_reset: got halted=%0b step=%0d ctl=%h, need 0/0/0000", halted, step, dut_ctl);
      end
      do_reset();
   endtask

   task automatic test_run_freeze();
      do_reset();
      run = 1'b1;
      ir_in = 8'h25;
      tick(); tick(); tick();
      run = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (step !== 3'd3 || dut_ctl !== 15'h0) begin
            errors++;
            $display("FAIL freeze[%0d]: got step=%0d ctl=%h, need 3/0000", i, step, dut_ctl);
         end
      end
      run = 1'b1;
      #1;
      for (int i = 3; i < 6; i++) begin
         checks++;
         if (step !== 3'(i % 5) || dut_ctl !== exp_ctl()) begin
            errors++;
            $display("FAIL resume%0d: got step=%0d ctl=%h, need step=%0d ctl=%h", i, step, dut_ctl, i % 5, exp_ctl());
         end
         tick();
      end
   endtask

   task automatic test_cond_jump();
      for (int k = 0; k < 4; k++) begin
         do_reset();
         run = 1'b1;
         ir_in = (k < 2) ? 8'h7C : 8'h85;
         flag_c = (k == 1);
         flag_z = (k == 3);
         tick(); tick();
         checks++;
         if (pc_load !== (cond_en && (k == 1 || k == 3)) || dut_ctl !== exp_ctl()) begin
            errors++;
            $display("FAIL cond_jump[%0d]: got pc_load=%0b ctl=%h, need pc_load=%0b ctl=%h", k, pc_load, dut_ctl, cond_en && (k == 1 || k == 3), exp_ctl());
         end
      end
      flag_c = 1'b0;
      flag_z = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset();
      run = 1'b1;
      ir_in = 8'h21;
      tick(); tick(); tick();
      checks++;
      if (dut_ctl !== (RAMR | BL)) begin
         errors++;
         $display("FAIL add_t3: got ctl=%h, need %h", dut_ctl, RAMR | BL);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({step, dut_ctl} !== {3'd0, 15'h0}) begin
         errors++;
         $display("FAIL async_reset: got step=%0d ctl=%h, need 0/0000", step, dut_ctl);
      end
      do_reset();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         run = ($urandom_range(0, 9) != 0);
         ir_in[3:0] = 4'($urandom);
         ir_in[7:4] = ($urandom_range(0, 49) == 0) ? 4'hF : 4'($urandom_range(0, 14));
         flag_c = 1'($urandom);
         flag_z = 1'($urandom);
         #1;
         checks++;
         if ({halted, step, dut_ctl} !== {m_halted, 3'(m_step), exp_ctl()}) begin
            errors++;
            $display("FAIL random[%0d]: got halted=%0b step=%0d ctl=%h, need %0b/%0d/%h ir=%h", i, halted, step, dut_ctl, m_halted, m_step, exp_ctl(), ir_in);
         end
         if (m_halted && $urandom_range(0, 3) == 0) do_reset();
         else tick();
      end
   endtask

   initial begin
`ifdef SEQ_COND_JUMP_EN
      cond_en = 1'b1;
`else
      cond_en = 1'b0;
`endif
      init_ucode();
      test_reset();
      test_fetch_nop();
      test_sub();
      test_halt();
      test_run_freeze();
      test_cond_jump();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
